// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM state encoding,
// default watchdog settings and a small wrap-around helper.
package mult_share_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_BUSY  = 3'd2,
        ST_RESP  = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    localparam int DEFAULT_TIMEOUT = 2047;
    localparam int DEFAULT_TW      = 12;

    // Next requester index with wrap-around at n (works for non-power-of-two n).
    function automatic int wrapInc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Bundle of requester-side and multiplier-core-side signals of the arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding logic (requesters, result consumer and the multiplier core).
interface mult_share_arbiter_if #(
    parameter int SIZEA = 521,
    parameter int SIZEB = 521,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*SIZEA-1:0]  req_a;
    logic [NREQ*SIZEB-1:0]  req_b;
    logic [NREQ-1:0]        req_ready;

    logic                   resp_valid;
    logic                   resp_ready;
    logic [IDW-1:0]         resp_id;
    logic [SIZEA+SIZEB-1:0] resp_c;
    logic                   resp_err;

    logic [SIZEA-1:0]       mul_a;
    logic [SIZEB-1:0]       mul_b;
    logic                   mul_start;
    logic                   mul_clr;
    logic                   mul_done;
    logic [SIZEA+SIZEB-1:0] mul_c;

    modport slave (
        input  req_valid, req_a, req_b, resp_ready, mul_done, mul_c,
        output req_ready, resp_valid, resp_id, resp_c, resp_err,
               mul_a, mul_b, mul_start, mul_clr
    );

    modport master (
        output req_valid, req_a, req_b, resp_ready, mul_done, mul_c,
        input  req_ready, resp_valid, resp_id, resp_c, resp_err,
               mul_a, mul_b, mul_start, mul_clr
    );

endinterface

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first asserted request at or
// after the pointer, wrapping past the highest index back to zero.
module rr_pick
    import mult_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [IDW-1:0]  o_gntId,
    output logic            o_any
);

    logic w_found;
    int   w_idx;

    // Walk all NREQ positions starting at the pointer and keep the first hit.
    always_comb begin
        w_found = 1'b0;
        o_gntId = '0;
        w_idx   = int'(i_ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                o_gntId = IDW'(w_idx);
            end
            w_idx = wrapInc(w_idx, NREQ);
        end
    end

    assign o_any = w_found;

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one digit-serial multiplier core among NREQ
// requesters. One operation is in flight at a time: grant, start the core,
// wait for done (or watchdog abort), present the tagged result, then clear
// the core before the next grant.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int SIZEA   = 521,
    parameter int SIZEB   = 521,
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ),
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int TW      = DEFAULT_TW
) (
    input logic                 clk,
    input logic                 rst,
    mult_share_arbiter_if.slave bus
);

    localparam int CW = SIZEA + SIZEB;

    state_t           r_state;
    state_t           w_nextState;

    logic [IDW-1:0]   w_pickId;
    logic             w_pickAny;
    logic [NREQ-1:0]  w_reqReady;
    logic             w_timeout;
    logic             w_handshake;

    logic [IDW-1:0]   r_gntId;
    logic [IDW-1:0]   r_rrPtr;
    logic [TW-1:0]    r_timer;
    logic [SIZEA-1:0] r_mulA;
    logic [SIZEB-1:0] r_mulB;
    logic             r_mulStart;
    logic             r_respValid;
    logic [IDW-1:0]   r_respId;
    logic [CW-1:0]    r_respC;
    logic             r_respErr;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rrPick (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rrPtr),
        .o_gntId (w_pickId),
        .o_any   (w_pickAny)
    );

    assign w_timeout   = (r_timer == TW'(TIMEOUT));
    assign w_handshake = r_respValid && bus.resp_ready;

    // State register; a low rst at the edge forces the FSM back to IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic plus the combinational one-hot grant pulse in IDLE.
    always_comb begin
        w_nextState = r_state;
        w_reqReady  = '0;
        case (r_state)
            ST_IDLE: begin
                if (rst && w_pickAny) begin
                    w_reqReady[w_pickId] = 1'b1;
                    w_nextState          = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_nextState = ST_BUSY;
            end
            ST_BUSY: begin
                if (bus.mul_done || w_timeout) begin
                    w_nextState = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_handshake) begin
                    w_nextState = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand latch, core start, watchdog timer, result capture, pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_gntId     <= '0;
            r_rrPtr     <= '0;
            r_timer     <= '0;
            r_mulA      <= '0;
            r_mulB      <= '0;
            r_mulStart  <= 1'b0;
            r_respValid <= 1'b0;
            r_respId    <= '0;
            r_respC     <= '0;
            r_respErr   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pickAny) begin
                        r_mulA  <= bus.req_a[int'(w_pickId)*SIZEA +: SIZEA];
                        r_mulB  <= bus.req_b[int'(w_pickId)*SIZEB +: SIZEB];
                        r_gntId <= w_pickId;
                    end
                end
                ST_ISSUE: begin
                    r_mulStart <= 1'b1;
                    r_timer    <= '0;
                end
                ST_BUSY: begin
                    r_timer <= r_timer + TW'(1);
                    if (bus.mul_done) begin
                        r_mulStart  <= 1'b0;
                        r_respValid <= 1'b1;
                        r_respId    <= r_gntId;
                        r_respC     <= bus.mul_c;
                        r_respErr   <= 1'b0;
                    end else if (w_timeout) begin
                        r_mulStart  <= 1'b0;
                        r_respValid <= 1'b1;
                        r_respId    <= r_gntId;
                        r_respC     <= '0;
                        r_respErr   <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (w_handshake) begin
                        r_respValid <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    r_rrPtr <= IDW'(wrapInc(int'(r_gntId), NREQ));
                end
                default: begin
                    r_mulStart <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = w_reqReady;
    assign bus.resp_valid = r_respValid;
    assign bus.resp_id    = r_respId;
    assign bus.resp_c     = r_respC;
    assign bus.resp_err   = r_respErr;
    assign bus.mul_a      = r_mulA;
    assign bus.mul_b      = r_mulB;
    assign bus.mul_start  = r_mulStart;
    // The core is held in reset alongside the arbiter and pulsed once per operation.
    assign bus.mul_clr    = !rst || (r_state == ST_CLEAR);

endmodule
